// File: rtl/periph_bus_pkg.sv
// Purpose: shared types for the XT peripheral bus decoder (FSM states, decode target descriptor).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t        bus cycle FSM state (IDLE, WAIT, HOLD)
//   target_kind_t  which slave class claimed the cycle
//   target_t       kind plus slot/region index of the claiming slave
package periph_bus_pkg;

  // Wide enough for any sensible slot/region count; upper bits simply stay zero.
  localparam int TGT_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_INTA,
    TGT_IO,
    TGT_MEM
  } target_kind_t;

  typedef struct packed {
    target_kind_t           kind;
    logic [TGT_IDX_W-1:0]   index;
  } target_t;

  localparam target_t TARGET_NONE = '{kind: TGT_NONE, index: '0};

endpackage

// File: rtl/bus_wait_timer.sv
// Purpose: per-cycle wait-state sequencer producing READY, plus the stuck-cycle timeout.
// Latency: READY drops the cycle after command start and stays low for exactly i_wait cycles.
// Backpressure: READY low is the backpressure to the bus master; release mid-wait aborts the cycle.
//
// Ports:
//   i_clock, i_reset_n        clock, synchronous active-low reset
//   i_cmd                     any bus strobe active
//   i_cmd_start               first cycle of a command (cmd rising)
//   i_wait                    wait states for the target claimed at command start
//   i_address                 bus address, captured when the timeout fires
//   o_ready                   registered READY
//   o_bus_timeout             one-cycle timeout pulse
//   o_timeout_address         address captured at the timeout
module bus_wait_timer
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_W      = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_cmd,
  input  logic              i_cmd_start,
  input  logic [WAIT_W-1:0] i_wait,
  input  logic [ADDR_W-1:0] i_address,
  output logic              o_ready,
  output logic              o_bus_timeout,
  output logic [ADDR_W-1:0] o_timeout_address
);

  // One extra count value so the counter can park past the fire point
  // and the pulse cannot repeat while the command stays stuck.
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t              r_state;
  logic [WAIT_W-1:0]   r_cnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_ready;
  logic                r_timeout;
  logic [ADDR_W-1:0]   r_taddr;

  logic w_tfire;
  assign w_tfire = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_ready   <= 1'b1;
      r_timeout <= 1'b0;
      r_taddr   <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          r_tcnt  <= '0;
          if (i_cmd_start) begin
            if (i_wait != '0) begin
              r_state <= WAIT;
              r_cnt   <= i_wait;
              r_ready <= 1'b0;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        WAIT: begin
          if (!i_cmd) begin
            // Master gave up mid-wait: abort and free the bus.
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else if (w_tfire) begin
            r_timeout <= 1'b1;
            r_taddr   <= i_address;
            r_tcnt    <= TCNT_W'(TIMEOUT_CYC);
            r_ready   <= 1'b1;
            r_state   <= HOLD;
          end else begin
            if (r_tcnt < TCNT_W'(TIMEOUT_CYC)) r_tcnt <= r_tcnt + 1'b1;
            r_cnt <= r_cnt - WAIT_W'(1);
            if (r_cnt == WAIT_W'(1)) begin
              r_ready <= 1'b1;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          r_ready <= 1'b1;
          if (!i_cmd) begin
            r_state <= IDLE;
          end else if (w_tfire) begin
            r_timeout <= 1'b1;
            r_taddr   <= i_address;
            r_tcnt    <= TCNT_W'(TIMEOUT_CYC);
          end else if (r_tcnt < TCNT_W'(TIMEOUT_CYC)) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready           = r_ready;
  assign o_bus_timeout     = r_timeout;
  assign o_timeout_address = r_taddr;

endmodule

// File: rtl/periph_bus_decoder.sv
// Purpose: XT chipset bus decoder: I/O slot and memory region selects, read data mux, READY and timeout.
// Latency: selects combinational; read data and READY registered (1 cycle).
// Backpressure: per-target wait states hold READY low; unclaimed/stuck cycles end with a timeout pulse.
//
// Ports:
//   clock, reset_n                      clock, synchronous active-low reset
//   address, address_enable_n           bus address; AEN high suppresses I/O decode
//   io_read_n/io_write_n                I/O strobes
//   memory_read_n/memory_write_n        memory strobes
//   interrupt_acknowledge_n             INTA strobe
//   cfg_mem_base/mask/enable            per-region base, compare mask, enable
//   cfg_io_wait/cfg_mem_wait            wait states per slot / region
//   io_slot_data/mem_region_data        slave read data
//   inta_data                           interrupt vector
//   io_slot_select_n/mem_region_select_n  combinational selects
//   data_bus_out/_from_chipset          registered read data and its valid
//   ready, bus_timeout, timeout_address READY, timeout pulse, captured address
module periph_bus_decoder
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 8,
  parameter int IO_SPACE_BITS = 10,
  parameter int IO_SLOT_SHIFT = 5,
  parameter int N_IO          = 8,
  parameter int N_MEM         = 4,
  parameter int WAIT_W        = 3,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      address_enable_n,
  input  logic                      io_read_n,
  input  logic                      io_write_n,
  input  logic                      memory_read_n,
  input  logic                      memory_write_n,
  input  logic                      interrupt_acknowledge_n,
  input  logic [N_MEM*ADDR_W-1:0]   cfg_mem_base,
  input  logic [N_MEM*ADDR_W-1:0]   cfg_mem_mask,
  input  logic [N_MEM-1:0]          cfg_mem_enable,
  input  logic [N_IO*WAIT_W-1:0]    cfg_io_wait,
  input  logic [N_MEM*WAIT_W-1:0]   cfg_mem_wait,
  input  logic [N_IO*DATA_W-1:0]    io_slot_data,
  input  logic [N_MEM*DATA_W-1:0]   mem_region_data,
  input  logic [DATA_W-1:0]         inta_data,
  output logic [N_IO-1:0]           io_slot_select_n,
  output logic [N_MEM-1:0]          mem_region_select_n,
  output logic [DATA_W-1:0]         data_bus_out,
  output logic                      data_bus_out_from_chipset,
  output logic                      ready,
  output logic                      bus_timeout,
  output logic [ADDR_W-1:0]         timeout_address
);

  localparam int SLOT_W = $clog2(N_IO);

  logic              w_io_strobe;
  logic              w_cmd;
  logic              w_cmd_start;
  logic              w_rd;
  logic              w_io_ok;
  logic [N_IO-1:0]   w_io_hit;
  logic [N_MEM-1:0]  w_mem_hit;
  target_t           w_tgt_now;
  target_t           w_tgt_act;
  logic [WAIT_W-1:0] w_wait;
  logic [DATA_W-1:0] w_mux;

  logic              r_cmd_q;
  target_t           r_tgt;
  logic [DATA_W-1:0] r_data;
  logic              r_from;

  assign w_io_strobe = ~io_read_n | ~io_write_n;
  assign w_cmd       = w_io_strobe | ~memory_read_n | ~memory_write_n | ~interrupt_acknowledge_n;
  assign w_cmd_start = w_cmd & ~r_cmd_q;
  assign w_rd        = ~io_read_n | ~memory_read_n | ~interrupt_acknowledge_n;

  // I/O decode: bits above the slot field inside the I/O space, and everything
  // above the I/O space, must be zero; AEN high means DMA owns the bus.
  assign w_io_ok = ~address_enable_n
                 && (address[IO_SPACE_BITS-1:IO_SLOT_SHIFT+SLOT_W] == '0)
                 && (address[ADDR_W-1:IO_SPACE_BITS] == '0);

  always_comb begin
    w_io_hit = '0;
    for (int k = 0; k < N_IO; k++) begin
      w_io_hit[k] = w_io_ok && (address[IO_SLOT_SHIFT +: SLOT_W] == SLOT_W'(k));
    end
  end

  always_comb begin
    w_mem_hit = '0;
    for (int i = 0; i < N_MEM; i++) begin
      w_mem_hit[i] = cfg_mem_enable[i]
                  && (((address ^ cfg_mem_base[i*ADDR_W +: ADDR_W])
                       & cfg_mem_mask[i*ADDR_W +: ADDR_W]) == '0);
    end
  end

  assign io_slot_select_n    = ~w_io_hit;
  assign mem_region_select_n = ~w_mem_hit;

  // Claiming target. An I/O strobe makes it an I/O cycle even when a memory
  // strobe is also low, so an undecoded I/O address is unclaimed rather than
  // falling through to a memory region. Descending loop: lowest region wins.
  always_comb begin
    w_tgt_now = TARGET_NONE;
    if (!interrupt_acknowledge_n) begin
      w_tgt_now.kind = TGT_INTA;
    end else if (w_io_strobe) begin
      for (int k = 0; k < N_IO; k++) begin
        if (w_io_hit[k]) begin
          w_tgt_now.kind  = TGT_IO;
          w_tgt_now.index = TGT_IDX_W'(k);
        end
      end
    end else begin
      for (int i = N_MEM - 1; i >= 0; i--) begin
        if (w_mem_hit[i]) begin
          w_tgt_now.kind  = TGT_MEM;
          w_tgt_now.index = TGT_IDX_W'(i);
        end
      end
    end
  end

  // Within a command the target is frozen; on its first cycle the latch is
  // not yet loaded so the live decode is used.
  assign w_tgt_act = r_cmd_q ? r_tgt : w_tgt_now;

  always_comb begin
    w_wait = '0;
    case (w_tgt_now.kind)
      TGT_IO: begin
        for (int k = 0; k < N_IO; k++) begin
          if (w_tgt_now.index == TGT_IDX_W'(k)) w_wait = cfg_io_wait[k*WAIT_W +: WAIT_W];
        end
      end
      TGT_MEM: begin
        for (int i = 0; i < N_MEM; i++) begin
          if (w_tgt_now.index == TGT_IDX_W'(i)) w_wait = cfg_mem_wait[i*WAIT_W +: WAIT_W];
        end
      end
      default: w_wait = '0;
    endcase
  end

  always_comb begin
    w_mux = '0;
    case (w_tgt_act.kind)
      TGT_INTA: w_mux = inta_data;
      TGT_IO: begin
        for (int k = 0; k < N_IO; k++) begin
          if (w_tgt_act.index == TGT_IDX_W'(k)) w_mux = io_slot_data[k*DATA_W +: DATA_W];
        end
      end
      TGT_MEM: begin
        for (int i = 0; i < N_MEM; i++) begin
          if (w_tgt_act.index == TGT_IDX_W'(i)) w_mux = mem_region_data[i*DATA_W +: DATA_W];
        end
      end
      default: w_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cmd_q <= 1'b0;
      r_tgt   <= TARGET_NONE;
      r_data  <= '0;
      r_from  <= 1'b0;
    end else begin
      r_cmd_q <= w_cmd;
      if (w_cmd_start) r_tgt <= w_tgt_now;
      if (w_rd && (w_tgt_act.kind != TGT_NONE)) begin
        r_data <= w_mux;
        r_from <= 1'b1;
      end else begin
        r_data <= '0;
        r_from <= 1'b0;
      end
    end
  end

  assign data_bus_out              = r_data;
  assign data_bus_out_from_chipset = r_from;

  bus_wait_timer #(
    .ADDR_W      (ADDR_W),
    .WAIT_W      (WAIT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clock           (clock),
    .i_reset_n         (reset_n),
    .i_cmd             (w_cmd),
    .i_cmd_start       (w_cmd_start),
    .i_wait            (w_wait),
    .i_address         (address),
    .o_ready           (ready),
    .o_bus_timeout     (bus_timeout),
    .o_timeout_address (timeout_address)
  );

endmodule

// File: tb/tb_periph_bus_decoder.sv
module tb_periph_bus_decoder;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int N_IO   = 8;
  localparam int N_MEM  = 4;
  localparam int WAIT_W = 3;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [ADDR_W-1:0]        address;
  logic                     address_enable_n;
  logic                     io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic                     interrupt_acknowledge_n;
  logic [N_MEM*ADDR_W-1:0]  cfg_mem_base, cfg_mem_mask;
  logic [N_MEM-1:0]         cfg_mem_enable;
  logic [N_IO*WAIT_W-1:0]   cfg_io_wait;
  logic [N_MEM*WAIT_W-1:0]  cfg_mem_wait;
  logic [N_IO*DATA_W-1:0]   io_slot_data;
  logic [N_MEM*DATA_W-1:0]  mem_region_data;
  logic [DATA_W-1:0]        inta_data;
  logic [N_IO-1:0]          io_slot_select_n;
  logic [N_MEM-1:0]         mem_region_select_n;
  logic [DATA_W-1:0]        data_bus_out;
  logic                     data_bus_out_from_chipset;
  logic                     ready;
  logic                     bus_timeout;
  logic [ADDR_W-1:0]        timeout_address;

  always #5 clock = ~clock;

  periph_bus_decoder dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .address                   (address),
    .address_enable_n          (address_enable_n),
    .io_read_n                 (io_read_n),
    .io_write_n                (io_write_n),
    .memory_read_n             (memory_read_n),
    .memory_write_n            (memory_write_n),
    .interrupt_acknowledge_n   (interrupt_acknowledge_n),
    .cfg_mem_base              (cfg_mem_base),
    .cfg_mem_mask              (cfg_mem_mask),
    .cfg_mem_enable            (cfg_mem_enable),
    .cfg_io_wait               (cfg_io_wait),
    .cfg_mem_wait              (cfg_mem_wait),
    .io_slot_data              (io_slot_data),
    .mem_region_data           (mem_region_data),
    .inta_data                 (inta_data),
    .io_slot_select_n          (io_slot_select_n),
    .mem_region_select_n       (mem_region_select_n),
    .data_bus_out              (data_bus_out),
    .data_bus_out_from_chipset (data_bus_out_from_chipset),
    .ready                     (ready),
    .bus_timeout               (bus_timeout),
    .timeout_address           (timeout_address)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              f;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic release_bus();
    io_read_n               = 1'b1;
    io_write_n              = 1'b1;
    memory_read_n           = 1'b1;
    memory_write_n          = 1'b1;
    interrupt_acknowledge_n = 1'b1;
  endtask

  task automatic push_rd(input logic [DATA_W-1:0] d, input logic f);
    rd_exp_t e;
    e.d = d;
    e.f = f;
    sb.push_back(e);
  endtask

  task automatic pop_rd(input string tag);
    rd_exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(data_bus_out), 32'(e.d));
      chk({tag, "_from"}, 32'(data_bus_out_from_chipset), 32'(e.f));
    end
  endtask

  initial begin
    int pulses;
    int at_i;

    reset_n          = 1'b0;
    address          = '0;
    address_enable_n = 1'b0;
    release_bus();
    // Region order in the packed vectors is region3..region0 (MSB first).
    cfg_mem_base   = {20'h00000, 20'h00000, 20'hB8000, 20'hA0000};
    cfg_mem_mask   = {20'h00000, 20'h00000, 20'hF8000, 20'hF0000};
    cfg_mem_enable = 4'b0011;
    cfg_mem_wait   = {3'd0, 3'd0, 3'd0, 3'd3};
    cfg_io_wait    = '0;
    cfg_io_wait[3*WAIT_W +: WAIT_W] = 3'd2;
    cfg_io_wait[5*WAIT_W +: WAIT_W] = 3'd7;
    for (int k = 0; k < N_IO; k++)  io_slot_data[k*DATA_W +: DATA_W]    = 8'h10 + 8'(k);
    for (int i = 0; i < N_MEM; i++) mem_region_data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
    inta_data = 8'h5C;

    // Reset state
    repeat (3) tick();
    chk("rst_ready",    32'(ready), 32'd1);
    chk("rst_data",     32'(data_bus_out), 32'd0);
    chk("rst_from",     32'(data_bus_out_from_chipset), 32'd0);
    chk("rst_timeout",  32'(bus_timeout), 32'd0);
    chk("rst_taddr",    32'(timeout_address), 32'd0);
    reset_n = 1'b1;
    tick();

    // I/O read slot 3, two wait states
    address   = 20'h00061;
    io_read_n = 1'b0;
    #1;
    chk("io3_sel", 32'(io_slot_select_n), 32'h000000F7);
    push_rd(8'h13, 1'b1);
    tick();
    pop_rd("io3");
    chk("io3_rdy_t1", 32'(ready), 32'd0);
    tick();
    chk("io3_rdy_t2", 32'(ready), 32'd0);
    tick();
    chk("io3_rdy_t3", 32'(ready), 32'd1);
    release_bus();
    push_rd(8'h00, 1'b0);
    tick();
    pop_rd("io3_rel");

    // Memory read region 1, zero wait states
    address       = 20'hB8010;
    memory_read_n = 1'b0;
    #1;
    chk("mem1_sel", 32'(mem_region_select_n), 32'h0000000D);
    push_rd(8'hA1, 1'b1);
    tick();
    pop_rd("mem1");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mem1_rdy_%0d", i), 32'(ready), 32'd1);
      tick();
    end
    release_bus();
    tick();

    // Unclaimed I/O read held until timeout
    address   = 20'h003F8;
    io_read_n = 1'b0;
    #1;
    chk("to_iosel",  32'(io_slot_select_n), 32'h000000FF);
    chk("to_memsel", 32'(mem_region_select_n), 32'h0000000F);
    push_rd(8'h00, 1'b0);
    tick();
    pop_rd("to");
    pulses = 0;
    at_i   = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (bus_timeout === 1'b1) begin
        pulses++;
        at_i = i;
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_cycle",  32'(at_i), 32'd64);
    chk("to_addr",   32'(timeout_address), 32'h000003F8);
    chk("to_from",   32'(data_bus_out_from_chipset), 32'd0);
    release_bus();
    tick();

    // INTA with I/O read also low: INTA wins, no wait states
    address                 = 20'h00061;
    interrupt_acknowledge_n = 1'b0;
    io_read_n               = 1'b0;
    push_rd(8'h5C, 1'b1);
    tick();
    pop_rd("inta");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("inta_rdy_%0d", i), 32'(ready), 32'd1);
      tick();
    end
    release_bus();
    tick();

    // Abort a 7-wait cycle after 3 low cycles, then start a new command at once
    address   = 20'h000A0;
    io_read_n = 1'b0;
    push_rd(8'h15, 1'b1);
    tick();
    pop_rd("ab5");
    chk("ab_rdy_1", 32'(ready), 32'd0);
    tick();
    chk("ab_rdy_2", 32'(ready), 32'd0);
    tick();
    chk("ab_rdy_3", 32'(ready), 32'd0);
    release_bus();
    push_rd(8'h00, 1'b0);
    tick();
    pop_rd("ab_rel");
    chk("ab_rdy_rel", 32'(ready), 32'd1);
    address   = 20'h00061;
    io_read_n = 1'b0;
    push_rd(8'h13, 1'b1);
    tick();
    pop_rd("ab_new");
    chk("ab_new_rdy1", 32'(ready), 32'd0);
    tick();
    chk("ab_new_rdy2", 32'(ready), 32'd0);
    tick();
    chk("ab_new_rdy3", 32'(ready), 32'd1);
    release_bus();
    tick();

    // Reset asserted during WAIT
    address   = 20'h000A0;
    io_read_n = 1'b0;
    tick();
    chk("mr_rdy_wait", 32'(ready), 32'd0);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mr_ready",   32'(ready), 32'd1);
    chk("mr_data",    32'(data_bus_out), 32'd0);
    chk("mr_from",    32'(data_bus_out_from_chipset), 32'd0);
    chk("mr_timeout", 32'(bus_timeout), 32'd0);
    chk("mr_taddr",   32'(timeout_address), 32'd0);
    reset_n = 1'b1;
    release_bus();
    tick();

    // AEN high suppresses I/O decode
    address_enable_n = 1'b1;
    address          = 20'h00061;
    io_read_n        = 1'b0;
    #1;
    chk("aen_sel", 32'(io_slot_select_n), 32'h000000FF);
    push_rd(8'h00, 1'b0);
    tick();
    pop_rd("aen");
    chk("aen_rdy", 32'(ready), 32'd1);
    release_bus();
    address_enable_n = 1'b0;
    tick();

    // Memory write never drives the data bus
    address        = 20'hB8010;
    memory_write_n = 1'b0;
    #1;
    chk("mw_sel", 32'(mem_region_select_n), 32'h0000000D);
    push_rd(8'h00, 1'b0);
    tick();
    pop_rd("mw");
    release_bus();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
